branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Sequences front-end recovery for the pipelined RV32I core after a taken branch or jump has been resolved in EX.
- Consumes the branch unit's take/kind decision and both candidate targets.
- Produces a registered PC redirect, IF/ID and ID/EX flush pulses, and an EX kill window for wrong-path instructions.
- Latches a sticky trap when a redirect target is misaligned.

Parameters:
- ADDR_WIDTH, 32, width of PC and target buses.
- SQUASH_CYCLES, 1, number of pipeline advances after the REDIRECT cycle during which EX resolutions are ignored; legal range 1..7.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard-unit stall; pipeline registers hold when high.
- ex_valid_i  input  1  EX holds a valid (non-bubble) instruction.
- take_i  input  1  branch unit decision: redirect required.
- branch_or_jalr_i  input  1  1 = PC-relative target (branch/jal), 0 = jalr target.
- branch_target_i  input  ADDR_WIDTH  PC+imm.
- jalr_target_i  input  ADDR_WIDTH  rs1+imm.
- redirect_o  output  1  PC mux select to next_pc_o, one-cycle pulse.
- next_pc_o  output  ADDR_WIDTH  registered redirect address.
- flush_if_id_o  output  1  clear IF/ID.
- flush_id_ex_o  output  1  clear ID/EX.
- ex_kill_o  output  1  suppress writeback/memory side effects of EX instruction.
- misalign_o  output  1  sticky target-misaligned trap.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, squash counter=0, next_pc_o=0.
  - All 1-bit outputs = 0.
  - Reset has priority over every other input in any state.
- Accepted resolution: accept = ex_valid_i & take_i & ~stall_i, evaluated only in IDLE.
- Target selection:
  - branch_or_jalr_i=1: target = branch_target_i.
  - branch_or_jalr_i=0: target = jalr_target_i with bit0 forced to 0.
- Misalignment: target[1]=1 (after bit0 clear) is misaligned.
- States:
  - IDLE: all pulses low. On accept with aligned target: latch next_pc_o<=target, go REDIRECT. On accept with misaligned target: next_pc_o unchanged, go TRAP. Otherwise stay.
  - REDIRECT (exactly one cycle, stall_i ignored): redirect_o=flush_if_id_o=flush_id_ex_o=ex_kill_o=1. Load squash counter with SQUASH_CYCLES, go SQUASH.
  - SQUASH: ex_kill_o=1, all other pulses 0. take_i and ex_valid_i are ignored. Counter decrements only on cycles with stall_i=0. When the counter is 1 and stall_i=0, go IDLE (ex_kill_o low from the next cycle).
  - TRAP: misalign_o=1, ex_kill_o=1, no redirect or flush. Held until reset.
- Latency: resolution accepted in cycle T → redirect_o high in T+1 → ex_kill_o high for T+1..T+1+SQUASH_CYCLES (stall-free case).
- Misalign boundary: a target of the form 0x...2 traps; 0x...1 from jalr is legal (bit0 cleared to 0x...0).
- All outputs are driven from registers or decoded from state only; no combinational input-to-output path.
- Back-to-back: a taken resolution arriving in REDIRECT or SQUASH is wrong-path by definition and is dropped.

Optional Feature:
- BRANCH_REDIRECT_STATS_EN defined:
  - Adds outputs stat_taken_o[31:0] and stat_squashed_o[31:0], both reset to 0.
  - stat_taken_o increments once per entry to REDIRECT.
  - stat_squashed_o increments on each SQUASH-state cycle with stall_i=0 and ex_valid_i=1.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Beq taken: T0 ex_valid=1, take=1, branch_or_jalr=1, branch_target=0x0000_0040 → T1 redirect=flush_if_id=flush_id_ex=ex_kill=1, next_pc=0x40; T2 only ex_kill=1; T3 all low (SQUASH_CYCLES=1).
- Jalr target clear: jalr_target=0x0000_1235, branch_or_jalr=0, take=1 → next_pc=0x1234, redirect pulse, misalign=0.
- Misaligned: jalr_target=0x0000_0102 → no redirect ever; misalign=1 and ex_kill=1 from T1 onward; reset clears both.
- Stall interplay:
  - take=1 with stall=1 in IDLE → no action.
  - In SQUASH, stall=1 for 3 cycles → ex_kill stays high those 3 cycles plus 1 unstalled cycle.
- Wrong-path drop: take=1 again in the REDIRECT and SQUASH cycles with target 0x80 → no second redirect; next_pc remains 0x40.
- Reset mid-SQUASH: reset=1 during SQUASH → next cycle all outputs 0, state IDLE; a fresh take is accepted immediately after.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Front-end recovery sequencer: turns an EX branch/jump resolution into
// a registered PC redirect, IF/ID and ID/EX flushes and an EX kill window.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   stall_i           hazard stall; pipeline registers hold while high
//   ex_valid_i        EX holds a real instruction
//   take_i            branch unit requests a redirect
//   branch_or_jalr_i  1 = PC-relative target, 0 = jalr target
//   branch_target_i   PC+imm
//   jalr_target_i     rs1+imm
//   redirect_o        one-cycle PC mux select toward next_pc_o
//   next_pc_o         registered redirect address
//   flush_if_id_o     clear IF/ID
//   flush_id_ex_o     clear ID/EX
//   ex_kill_o         suppress side effects of the EX instruction
//   misalign_o        sticky misaligned-target trap
// Optional (BRANCH_REDIRECT_STATS_EN):
//   stat_taken_o      redirects issued, wraps at 2^32
//   stat_squashed_o   valid EX instructions killed in SQUASH, wraps at 2^32
module branch_redirect_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int SQUASH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  ex_valid_i,
    input  logic                  take_i,
    input  logic                  branch_or_jalr_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic [ADDR_WIDTH-1:0] jalr_target_i,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic                  ex_kill_o,
    output logic                  misalign_o
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]           stat_taken_o,
    output logic [31:0]           stat_squashed_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        SQUASH,
        TRAP
    } state_t;

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] target;
    logic                  accept;
    logic                  misaligned;

    // jalr targets always have bit0 cleared; only bit1 can misalign.
    always_comb begin
        target = branch_or_jalr_i
               ? branch_target_i
               : {jalr_target_i[ADDR_WIDTH-1:1], 1'b0};
        misaligned = target[1];
        accept = ex_valid_i & take_i & ~stall_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d = TRAP;
                    end else begin
                        pc_d    = target;
                        state_d = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                cnt_d   = SQ_LOAD;
                state_d = SQUASH;
            end
            SQUASH: begin
                // Only pipeline advances count toward the kill window.
                if (!stall_i) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    assign redirect_o    = (state_q == REDIRECT);
    assign flush_if_id_o = (state_q == REDIRECT);
    assign flush_id_ex_o = (state_q == REDIRECT);
    assign ex_kill_o     = (state_q != IDLE);
    assign misalign_o    = (state_q == TRAP);
    assign next_pc_o     = pc_q;

`ifdef BRANCH_REDIRECT_STATS_EN
    logic [31:0] taken_q;
    logic [31:0] squashed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q    <= '0;
            squashed_q <= '0;
        end else begin
            if (state_q == IDLE && state_d == REDIRECT) begin
                taken_q <= taken_q + 32'd1;
            end
            if (state_q == SQUASH && !stall_i && ex_valid_i) begin
                squashed_q <= squashed_q + 32'd1;
            end
        end
    end

    assign stat_taken_o    = taken_q;
    assign stat_squashed_o = squashed_q;
`endif

endmodule
